pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//   Receive side of the servo/ESC-style PWM link: measures the high time and period of an
//   incoming PWM pulse train (nominal 106_400-cycle frame at 53.20 MHz, 33_200..103_200 high).
//   Sits between a board input pin and flight-control logic; reports each completed frame as
//   a one-cycle strobe with cycle-accurate width/period, flags out-of-range pulses and loss of signal.
// PARAMETERS
//   CNT_W       21          width of all cycle counters and width/period outputs
//   FILT_LEN    3           consecutive equal samples required to accept a level change (1..15)
//   MIN_HIGH    26_600      shortest legal high time, cycles (0.5 ms)
//   MAX_HIGH    133_000     longest legal high time, cycles (2.5 ms)
//   MAX_PERIOD  1_064_000   frame longer than this = signal lost (20 ms); must be < 2**CNT_W
// PORTS
//   clk          in   1      system clock, 53.20 MHz from OSCH
//   rst_n        in   1      synchronous reset, active low
//   pwm_in       in   1      asynchronous PWM input pin
//   high_width   out  CNT_W  high time of last valid frame, cycles
//   period       out  CNT_W  rise-to-rise period of last valid frame, cycles
//   sample_valid out  1      one-cycle strobe: high_width/period just updated
//   range_err    out  1      one-cycle strobe: frame completed but high time out of range
//   signal_lost  out  1      level: no valid frame since reset or since last timeout
// BEHAVIOUR
//   Reset (rst_n=0 at posedge clk): high_width=0, period=0, sample_valid=0, range_err=0,
//     signal_lost=1, FSM=WAIT_LOW, counters=0, filter state=0. Reset dominates all events.
//   Front end: 2-FF synchronizer, then filter; filtered level flips only after FILT_LEN
//     consecutive synchronized samples differ from it. Edges = filtered-level transitions.
//     Fixed front-end delay (2+FILT_LEN cycles) applies to both edges -> widths unbiased.
//   FSM:
//     WAIT_LOW  : ignore input until filtered level is 0 (never measure a partial pulse) -> WAIT_RISE
//     WAIT_RISE : on rise: hi_cnt=1, per_cnt=1 -> HIGH
//     HIGH      : hi_cnt++, per_cnt++; on fall: latch hi_cnt -> LOW
//     LOW       : per_cnt++; on rise: frame complete -> evaluate, hi_cnt=1, per_cnt=1, stay measuring (HIGH)
//   Counting: hi_cnt = number of cycles filtered level was 1; per_cnt = cycles from rise to next rise.
//     53_200 high + 53_200 low -> high_width=53_200, period=106_400 exactly.
//   Evaluate (cycle after rise detection): if MIN_HIGH <= hi <= MAX_HIGH: update high_width,
//     period, pulse sample_valid, clear signal_lost. Else pulse range_err; outputs hold.
//     sample_valid and range_err never assert in the same cycle.
//   Timeout: per_cnt reaching MAX_PERIOD in WAIT_RISE/HIGH/LOW -> signal_lost=1, no strobe,
//     counters cleared, FSM -> WAIT_LOW (stuck-high and stuck-low both caught). Counters saturate,
//     never wrap. high_width/period keep last valid values while signal_lost=1.
//   Rise arriving in the same cycle as timeout: timeout wins, rise ignored.
//   Reset mid-frame: partial measurement discarded, no strobe.
// STRUCTURE
//   Shared header pwm_defs.vh (also used by pwm_generator): frame/high-time cycle constants
//     (106_400, 33_200, 53_200, 103_200), MIN_HIGH/MAX_HIGH/MAX_PERIOD defaults, FSM state codes.
//   Sub-module pwm_in_filter: synchronizer + FILT_LEN debounce; outputs level, rise, fall pulses.
//   pwm_capture: FSM, hi/per counters, range compare, output registers.
// TESTING
//   1 Drive 53_200 high / 53_200 low x3 frames -> sample_valid each rise after first full frame,
//     high_width=53_200, period=106_400, signal_lost 1->0 on first strobe.
//   2 Release reset with pwm_in=1 mid-pulse -> no strobe until one full low->high->low->high
//     frame; first reported frame is complete.
//   3 High 10_000 cycles (below MIN_HIGH) -> range_err 1 cycle, no sample_valid, outputs unchanged.
//   4 Hold pwm_in=0 after valid frames -> signal_lost=1 exactly MAX_PERIOD cycles after last rise;
//     repeat with pwm_in stuck 1 -> same.
//   5 Inject 1- and 2-cycle glitches (FILT_LEN=3) inside high and low phases -> widths unchanged.
//   6 Assert rst_n=0 for 1 cycle mid-HIGH -> all outputs at reset values next cycle, no strobe
//     from the interrupted frame.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared constants, types and helpers for the PWM capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a; results are strobes with no ready, nothing stalls.
package pwm_capture_pkg;

    // Counter / output width; must hold the longest frame before loss.
    localparam int CNT_W = 21;

    // Nominal link timing at 53.20 MHz, in clock cycles.
    localparam int FRAME_CYC    = 106_400;
    localparam int HIGH_LO_CYC  = 33_200;
    localparam int HIGH_MID_CYC = 53_200;
    localparam int HIGH_HI_CYC  = 103_200;

    // Acceptance window and loss-of-signal limit defaults.
    localparam int MIN_HIGH_DEF   = 26_600;
    localparam int MAX_HIGH_DEF   = 133_000;
    localparam int MAX_PERIOD_DEF = 1_064_000;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2,
        LOW       = 2'd3
    } cap_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Result bus of the PWM capture: measured widths plus status strobes.
// Latency: n/a (wires only).
// Backpressure: none; the consumer must take sample_valid/range_err when they pulse.
// Ports (master = capture side drives):
//   high_width, period : last accepted frame, cycles
//   sample_valid       : one-cycle strobe, high_width/period just updated
//   range_err          : one-cycle strobe, frame completed with high time out of range
//   signal_lost        : level, no valid frame since reset or last timeout
interface pwm_capture_if;

    pwm_capture_pkg::cnt_t high_width;
    pwm_capture_pkg::cnt_t period;
    logic                  sample_valid;
    logic                  range_err;
    logic                  signal_lost;

    modport master (
        output high_width,
        output period,
        output sample_valid,
        output range_err,
        output signal_lost
    );

    modport slave (
        input high_width,
        input period,
        input sample_valid,
        input range_err,
        input signal_lost
    );

endinterface

// File: rtl/pwm_capture_filter.sv
// Input front end: 2-FF synchronizer followed by a FILT_LEN-sample debounce.
// Latency: 2 + FILT_LEN cycles from pin to level, identical for both edges.
// Backpressure: none; rise/fall are single-cycle pulses aligned with the new level.
// Ports: clk, rst_n (sync, active low), pwm_in (async pin) -> level, rise, fall.
module pwm_capture_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [3:0] RUN_LAST = 4'(FILT_LEN - 1);

    logic       sync1;
    logic       sync2;
    logic [3:0] run;    // consecutive synced samples disagreeing with level, minus one

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            run   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            if (sync2 == level) begin
                // Any agreeing sample restarts the run, so short glitches die here.
                run <= '0;
            end else if (run == RUN_LAST) begin
                run   <= '0;
                level <= sync2;
                rise  <= sync2;
                fall  <= !sync2;
            end else begin
                run <= run + 4'd1;
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and rise-to-rise period, flags range errors and loss of signal.
// Latency: results strobe one cycle after the filtered rise that closes a frame (2+FILT_LEN+1 from pin).
// Backpressure: none; sample_valid/range_err are one-cycle strobes, outputs hold between frames.
// Ports: clk, rst_n (sync, active low), pwm_in (async pin), res (result bus, master side).
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int FILT_LEN   = 3,
    parameter int MIN_HIGH   = MIN_HIGH_DEF,
    parameter int MAX_HIGH   = MAX_HIGH_DEF,
    parameter int MAX_PERIOD = MAX_PERIOD_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwm_in,
    pwm_capture_if.master res
);

    localparam cnt_t MIN_C  = cnt_t'(MIN_HIGH);
    localparam cnt_t MAX_C  = cnt_t'(MAX_HIGH);
    localparam cnt_t MAXP_C = cnt_t'(MAX_PERIOD);
    // The filtered level must stay low longer than the front-end pipeline is deep
    // before arming, otherwise a pin already high at reset release would reach the
    // filter output after arming and be measured as a (partial) pulse.
    localparam logic [4:0] SETTLE_LAST = 5'(FILT_LEN + 2);

    logic       lvl;
    logic       rise;
    logic       fall;

    cap_state_t state;
    cnt_t       hi_cnt;
    cnt_t       per_cnt;
    cnt_t       hi_lat;
    logic [4:0] settle;

    cnt_t       high_width_q;
    cnt_t       period_q;
    logic       sample_valid_q;
    logic       range_err_q;
    logic       signal_lost_q;

    pwm_capture_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .level  (lvl),
        .rise   (rise),
        .fall   (fall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= WAIT_LOW;
            hi_cnt         <= '0;
            per_cnt        <= '0;
            hi_lat         <= '0;
            settle         <= '0;
            high_width_q   <= '0;
            period_q       <= '0;
            sample_valid_q <= 1'b0;
            range_err_q    <= 1'b0;
            signal_lost_q  <= 1'b1;
        end else begin
            sample_valid_q <= 1'b0;
            range_err_q    <= 1'b0;

            if (state != WAIT_LOW && per_cnt >= MAXP_C) begin
                // Loss of signal beats a rise in the same cycle; catches stuck high and stuck low.
                signal_lost_q <= 1'b1;
                hi_cnt        <= '0;
                per_cnt       <= '0;
                hi_lat        <= '0;
                settle        <= '0;
                state         <= WAIT_LOW;
            end else begin
                case (state)
                    WAIT_LOW: begin
                        if (lvl) begin
                            settle <= '0;
                        end else if (settle == SETTLE_LAST) begin
                            settle <= '0;
                            state  <= WAIT_RISE;
                        end else begin
                            settle <= settle + 5'd1;
                        end
                    end

                    WAIT_RISE: begin
                        if (rise) begin
                            hi_cnt  <= cnt_t'(1);
                            per_cnt <= cnt_t'(1);
                            state   <= HIGH;
                        end else begin
                            per_cnt <= sat_inc(per_cnt);
                        end
                    end

                    HIGH: begin
                        per_cnt <= sat_inc(per_cnt);
                        if (fall) begin
                            hi_lat <= hi_cnt;
                            state  <= LOW;
                        end else begin
                            hi_cnt <= sat_inc(hi_cnt);
                        end
                    end

                    LOW: begin
                        if (rise) begin
                            // per_cnt now equals the rise-to-rise distance of the closed frame.
                            if (hi_lat >= MIN_C && hi_lat <= MAX_C) begin
                                high_width_q   <= hi_lat;
                                period_q       <= per_cnt;
                                sample_valid_q <= 1'b1;
                                signal_lost_q  <= 1'b0;
                            end else begin
                                range_err_q <= 1'b1;
                            end
                            hi_cnt  <= cnt_t'(1);
                            per_cnt <= cnt_t'(1);
                            state   <= HIGH;
                        end else begin
                            per_cnt <= sat_inc(per_cnt);
                        end
                    end

                    default: state <= WAIT_LOW;
                endcase
            end
        end
    end

    assign res.high_width   = high_width_q;
    assign res.period       = period_q;
    assign res.sample_valid = sample_valid_q;
    assign res.range_err    = range_err_q;
    assign res.signal_lost  = signal_lost_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with scaled-down timing constants.
// Latency: loss-of-signal delay checked as MAXP + 2 sync + FL filter + 1 output register.
// Backpressure: none; a negedge monitor counts every strobe.
module tb_pwm_capture;

    localparam int FL   = 3;
    localparam int MINH = 40;
    localparam int MAXH = 250;
    localparam int MAXP = 1000;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic pwm_in = 1'b0;

    int cyc      = 0;
    int sv_cnt   = 0;
    int re_cnt   = 0;
    int both_cnt = 0;
    int vec_cnt  = 0;
    int err_cnt  = 0;
    int base_sv  = 0;
    int base_re  = 0;
    int c0       = 0;

    pwm_capture_if res_if ();

    pwm_capture #(
        .FILT_LEN   (FL),
        .MIN_HIGH   (MINH),
        .MAX_HIGH   (MAXH),
        .MAX_PERIOD (MAXP)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .res    (res_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (res_if.sample_valid) sv_cnt <= sv_cnt + 1;
        if (res_if.range_err) re_cnt <= re_cnt + 1;
        if (res_if.sample_valid && res_if.range_err) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt = vec_cnt + 1;
        if (got !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        pwm_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int h, input int l);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    task automatic snap();
        base_sv = sv_cnt;
        base_re = re_cnt;
    endtask

    task automatic chk_out(input string tag, input int hw, input int per);
        chk({tag, "_hw"}, 32'(res_if.high_width), hw);
        chk({tag, "_per"}, 32'(res_if.period), per);
    endtask

    task automatic chk_reset(input string tag);
        chk_out(tag, 0, 0);
        chk({tag, "_sv"}, 32'(res_if.sample_valid), 0);
        chk({tag, "_re"}, 32'(res_if.range_err), 0);
        chk({tag, "_lost"}, 32'(res_if.signal_lost), 1);
    endtask

    // Bounded wait for signal_lost; an expired bound shows up as a wrong delay.
    task automatic wait_lost(input string tag);
        for (int i = 0; i < 3 * MAXP; i++) begin
            @(negedge clk);
            if (res_if.signal_lost) break;
        end
        chk(tag, cyc - c0, MAXP + FL + 3);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with the pin already high (mid-pulse).
        pwm_in = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");

        // Partial pulse at release must not be measured.
        rst_n = 1'b1;
        drive(1'b1, 80);
        drive(1'b0, 100);
        frame(100, 100);
        chk("partial_nostrobe", sv_cnt, 0);
        chk("lost_before_first", 32'(res_if.signal_lost), 1);

        // Nominal frames, scaled 100 high / 100 low.
        frame(100, 100);
        chk("first_strobe_cnt", sv_cnt, 1);
        chk_out("first", 100, 200);
        chk("lost_cleared", 32'(res_if.signal_lost), 0);
        frame(100, 100);
        frame(100, 100);
        chk("nominal_cnt", sv_cnt, 3);
        chk("nominal_re", re_cnt, 0);
        chk_out("nominal", 100, 200);

        // Short pulse: range error, outputs hold.
        snap();
        frame(10, 190);
        frame(100, 100);
        chk("short_sv", sv_cnt - base_sv, 1);
        chk("short_re", re_cnt - base_re, 1);
        chk_out("short_hold", 100, 200);

        // Acceptance window edges.
        snap();
        frame(40, 160);
        frame(39, 161);
        chk_out("min_edge", 40, 200);
        frame(250, 150);
        frame(251, 149);
        chk_out("max_edge", 250, 400);
        chk("edge_re_39", re_cnt - base_re, 1);
        frame(100, 100);
        chk("edge_re_251", re_cnt - base_re, 2);
        chk("edge_sv", sv_cnt - base_sv, 3);
        chk_out("edge_hold", 250, 400);

        // 1- and 2-cycle glitches inside both phases.
        snap();
        drive(1'b1, 30); drive(1'b0, 1); drive(1'b1, 30); drive(1'b0, 2); drive(1'b1, 37);
        drive(1'b0, 30); drive(1'b1, 1); drive(1'b0, 30); drive(1'b1, 2); drive(1'b0, 37);
        frame(100, 100);
        chk("glitch_sv", sv_cnt - base_sv, 2);
        chk("glitch_re", re_cnt - base_re, 0);
        chk_out("glitch", 100, 200);

        // Stuck low after a rise.
        snap();
        pwm_in = 1'b1;
        c0 = cyc;
        repeat (100) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        wait_lost("lost_low_delay");
        chk("lost_low_sv", sv_cnt - base_sv, 1);
        chk_out("lost_low_hold", 100, 200);

        // Regain, then stuck high.
        drive(1'b0, 20);
        frame(100, 100);
        frame(100, 100);
        chk("regain_lost", 32'(res_if.signal_lost), 0);
        snap();
        pwm_in = 1'b1;
        c0 = cyc;
        wait_lost("lost_high_delay");
        chk("lost_high_sv", sv_cnt - base_sv, 1);
        chk("lost_high_re", re_cnt - base_re, 0);
        chk_out("lost_high_hold", 100, 200);

        // One-cycle reset in the middle of a high phase.
        drive(1'b0, 50);
        frame(100, 100);
        frame(100, 100);
        drive(1'b1, 50);
        chk("pre_rst_lost", 32'(res_if.signal_lost), 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_reset("midrst");
        snap();
        drive(1'b1, 50);
        drive(1'b0, 100);
        frame(100, 100);
        drive(1'b1, 100);
        drive(1'b0, 20);
        chk("midrst_sv", sv_cnt - base_sv, 1);
        chk("midrst_re", re_cnt - base_re, 0);
        chk_out("midrst", 100, 200);

        chk("sv_re_overlap", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
